// File: rtl/atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// atm_session_ctrl
//
// Sequences one ATM session from card insertion to card return: PIN
// verification through an external verifier (with bounded retries and card
// retention), inactivity timeouts in the two user-wait states, a balance check,
// the cash-dispenser handshake and the account balance write-back.
//
// Optional feature (compile-time macro ATM_DAILY_LIMIT_EN):
//   When defined, adds the day_clr input, the DAILY_LIMIT parameter and an
//   accumulator of dispensed amounts. A withdrawal is refused in CHECK when it
//   would push the accumulated total above DAILY_LIMIT. When undefined, none of
//   this exists.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   synchronous active-low reset
//   card_insert  in   level, card present in the slot
//   pin_enter    in   pulse, PIN entry complete
//   cancel       in   pulse, user abort
//   pin_req      out  level, high for the whole VERIFY state
//   pin_ack      in   verifier response strobe
//   pin_match    in   verifier result, valid with pin_ack
//   txn_confirm  in   pulse, withdrawal confirmed (latches txn_amount)
//   txn_amount   in   requested amount
//   balance      in   current account balance
//   disp_start   out  pulse, dispense request
//   disp_done    in   dispenser success strobe
//   disp_fault   in   dispenser failure strobe
//   balance_we   out  pulse, balance write strobe
//   new_balance  out  balance - amount, valid with balance_we (0 otherwise)
//   txn_complete out  pulse, successful withdrawal
//   txn_failed   out  pulse, session failed
//   card_eject   out  pulse, card returned
//   card_retain  out  pulse, card kept
//   tries        out  failed PIN attempts this session
//   state_o      out  current state encoding
//   day_clr      in   pulse, clears the daily accumulator (ATM_DAILY_LIMIT_EN)
// -----------------------------------------------------------------------------
module atm_session_ctrl #(
  parameter int AMT_W       = 16,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
`ifdef ATM_DAILY_LIMIT_EN
  ,
  parameter int DAILY_LIMIT = 500
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             card_insert,
  input  logic             pin_enter,
  input  logic             cancel,
  output logic             pin_req,
  input  logic             pin_ack,
  input  logic             pin_match,
  input  logic             txn_confirm,
  input  logic [AMT_W-1:0] txn_amount,
  input  logic [AMT_W-1:0] balance,
  output logic             disp_start,
  input  logic             disp_done,
  input  logic             disp_fault,
  output logic             balance_we,
  output logic [AMT_W-1:0] new_balance,
  output logic             txn_complete,
  output logic             txn_failed,
  output logic             card_eject,
  output logic             card_retain,
  output logic [2:0]       tries,
  output logic [2:0]       state_o
`ifdef ATM_DAILY_LIMIT_EN
  ,
  input  logic             day_clr
`endif
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PIN = 3'd1,
    S_VERIFY   = 3'd2,
    S_WAIT_TXN = 3'd3,
    S_CHECK    = 3'd4,
    S_DISPENSE = 3'd5,
    S_EJECT    = 3'd6,
    S_RETAIN   = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         tries_q, tries_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [AMT_W-1:0]   amount_q, amount_d;

  logic               pin_req_q, pin_req_d;
  logic               disp_start_q, disp_start_d;
  logic               balance_we_q, balance_we_d;
  logic [AMT_W-1:0]   new_balance_q, new_balance_d;
  logic               txn_complete_q, txn_complete_d;
  logic               txn_failed_q, txn_failed_d;
  logic               card_eject_q, card_eject_d;
  logic               card_retain_q, card_retain_d;

  logic               timeout;
  logic               over_limit;

  // The timer counts cycles already spent in the current wait state, so the
  // last allowed cycle is the one where it reads TIMEOUT_CYC-1.
  assign timeout = (timer_q == TIMER_W'(TIMEOUT_CYC - 1));

`ifdef ATM_DAILY_LIMIT_EN
  localparam logic [AMT_W+1:0] LIMIT = (AMT_W + 2)'(DAILY_LIMIT);

  logic [AMT_W:0] accum_q, accum_d;

  // One extra bit on the sum so accum + amount cannot wrap before the compare.
  assign over_limit = ({1'b0, accum_q} + {2'b00, amount_q}) > LIMIT;

  // The add happens while txn_complete is visible; amount_q is still the
  // dispensed amount then. A coincident day_clr drops the old total but keeps
  // this withdrawal.
  always_comb begin
    accum_d = (day_clr ? {(AMT_W + 1){1'b0}} : accum_q)
            + (txn_complete_q ? {1'b0, amount_q} : {(AMT_W + 1){1'b0}});
  end
`else
  assign over_limit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    tries_d        = tries_q;
    timer_d        = timer_q;
    amount_d       = amount_q;
    disp_start_d   = 1'b0;
    balance_we_d   = 1'b0;
    new_balance_d  = '0;
    txn_complete_d = 1'b0;
    txn_failed_d   = 1'b0;
    card_eject_d   = 1'b0;
    card_retain_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (card_insert) begin
          state_d = S_WAIT_PIN;
          tries_d = '0;
          timer_d = '0;
        end
      end

      S_WAIT_PIN: begin
        timer_d = timer_q + 1'b1;
        if (!card_insert) begin
          state_d      = S_IDLE;
          txn_failed_d = 1'b1;
        end else if (cancel) begin
          state_d      = S_EJECT;
          txn_failed_d = 1'b1;
          card_eject_d = 1'b1;
        end else if (pin_enter) begin
          state_d = S_VERIFY;
        end else if (timeout) begin
          state_d      = S_EJECT;
          txn_failed_d = 1'b1;
          card_eject_d = 1'b1;
        end
      end

      // No timeout here: the verifier is trusted to answer eventually.
      S_VERIFY: begin
        if (!card_insert) begin
          state_d      = S_IDLE;
          txn_failed_d = 1'b1;
        end else if (pin_ack) begin
          if (pin_match) begin
            state_d = S_WAIT_TXN;
            timer_d = '0;
          end else begin
            tries_d = tries_q + 3'd1;
            if (tries_d == 3'(MAX_TRIES)) begin
              state_d       = S_RETAIN;
              txn_failed_d  = 1'b1;
              card_retain_d = 1'b1;
            end else begin
              state_d = S_WAIT_PIN;
              timer_d = '0;
            end
          end
        end
      end

      S_WAIT_TXN: begin
        timer_d = timer_q + 1'b1;
        if (!card_insert) begin
          state_d      = S_IDLE;
          txn_failed_d = 1'b1;
        end else if (cancel) begin
          state_d      = S_EJECT;
          txn_failed_d = 1'b1;
          card_eject_d = 1'b1;
        end else if (txn_confirm) begin
          state_d  = S_CHECK;
          amount_d = txn_amount;
        end else if (timeout) begin
          state_d      = S_EJECT;
          txn_failed_d = 1'b1;
          card_eject_d = 1'b1;
        end
      end

      S_CHECK: begin
        if (!card_insert) begin
          state_d      = S_IDLE;
          txn_failed_d = 1'b1;
        end else if ((amount_q == '0) || (amount_q > balance) || over_limit) begin
          state_d      = S_EJECT;
          txn_failed_d = 1'b1;
          card_eject_d = 1'b1;
        end else begin
          state_d      = S_DISPENSE;
          disp_start_d = 1'b1;
        end
      end

      // Card removal is deliberately ignored: cash may already be moving.
      S_DISPENSE: begin
        if (disp_fault) begin
          state_d      = S_EJECT;
          txn_failed_d = 1'b1;
          card_eject_d = 1'b1;
        end else if (disp_done) begin
          state_d        = S_EJECT;
          balance_we_d   = 1'b1;
          new_balance_d  = balance - amount_q;
          txn_complete_d = 1'b1;
          card_eject_d   = 1'b1;
        end
      end

      S_EJECT, S_RETAIN: begin
        if (!card_insert) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered from the next state so the request drops on the same edge
    // that leaves VERIFY, including an abort on card removal.
    pin_req_d = (state_d == S_VERIFY);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      tries_q        <= '0;
      timer_q        <= '0;
      amount_q       <= '0;
      pin_req_q      <= 1'b0;
      disp_start_q   <= 1'b0;
      balance_we_q   <= 1'b0;
      new_balance_q  <= '0;
      txn_complete_q <= 1'b0;
      txn_failed_q   <= 1'b0;
      card_eject_q   <= 1'b0;
      card_retain_q  <= 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
      accum_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      tries_q        <= tries_d;
      timer_q        <= timer_d;
      amount_q       <= amount_d;
      pin_req_q      <= pin_req_d;
      disp_start_q   <= disp_start_d;
      balance_we_q   <= balance_we_d;
      new_balance_q  <= new_balance_d;
      txn_complete_q <= txn_complete_d;
      txn_failed_q   <= txn_failed_d;
      card_eject_q   <= card_eject_d;
      card_retain_q  <= card_retain_d;
`ifdef ATM_DAILY_LIMIT_EN
      accum_q        <= accum_d;
`endif
    end
  end

  assign pin_req      = pin_req_q;
  assign disp_start   = disp_start_q;
  assign balance_we   = balance_we_q;
  assign new_balance  = new_balance_q;
  assign txn_complete = txn_complete_q;
  assign txn_failed   = txn_failed_q;
  assign card_eject   = card_eject_q;
  assign card_retain  = card_retain_q;
  assign tries        = tries_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atm_session_ctrl
//
// Directed session scenarios followed by biased random stimulus, all checked
// cycle by cycle against a behavioural model of the session rules.
// -----------------------------------------------------------------------------
module tb_atm_session_ctrl;

  localparam int AMT_W       = 16;
  localparam int MAX_TRIES   = 3;
  localparam int TIMEOUT_CYC = 10;
  localparam int DAILY_LIMIT = 500;
`ifdef ATM_DAILY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int IDLE = 0, WAIT_PIN = 1, VERIFY = 2, WAIT_TXN = 3;
  localparam int CHECK = 4, DISPENSE = 5, EJECT = 6, RETAIN = 7;

  logic             clk;
  logic             reset_n;
  logic             card_insert;
  logic             pin_enter;
  logic             cancel;
  logic             pin_req;
  logic             pin_ack;
  logic             pin_match;
  logic             txn_confirm;
  logic [AMT_W-1:0] txn_amount;
  logic [AMT_W-1:0] balance;
  logic             disp_start;
  logic             disp_done;
  logic             disp_fault;
  logic             balance_we;
  logic [AMT_W-1:0] new_balance;
  logic             txn_complete;
  logic             txn_failed;
  logic             card_eject;
  logic             card_retain;
  logic [2:0]       tries;
  logic [2:0]       state_o;
  logic             day_clr;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  int m_state, m_tries, m_wait, m_amt, m_accum;
  bit e_pin_req, e_ds, e_bwe, e_tc, e_tf, e_ej, e_rt;
  int e_nb;

  atm_session_ctrl #(
    .AMT_W       (AMT_W),
    .MAX_TRIES   (MAX_TRIES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
`ifdef ATM_DAILY_LIMIT_EN
    ,
    .DAILY_LIMIT (DAILY_LIMIT)
`endif
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .card_insert  (card_insert),
    .pin_enter    (pin_enter),
    .cancel       (cancel),
    .pin_req      (pin_req),
    .pin_ack      (pin_ack),
    .pin_match    (pin_match),
    .txn_confirm  (txn_confirm),
    .txn_amount   (txn_amount),
    .balance      (balance),
    .disp_start   (disp_start),
    .disp_done    (disp_done),
    .disp_fault   (disp_fault),
    .balance_we   (balance_we),
    .new_balance  (new_balance),
    .txn_complete (txn_complete),
    .txn_failed   (txn_failed),
    .card_eject   (card_eject),
    .card_retain  (card_retain),
    .tries        (tries),
    .state_o      (state_o)
`ifdef ATM_DAILY_LIMIT_EN
    ,
    .day_clr      (day_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_fail_eject();
    m_state = EJECT;
    e_tf    = 1'b1;
    e_ej    = 1'b1;
  endtask

  // Applies the session rules to the inputs present at this clock edge.
  task automatic model_update();
    bit prev_tc;
    bit event_go;
    int bal;
    prev_tc = e_tc;
    bal     = int'(balance);
    e_ds = 0; e_bwe = 0; e_nb = 0; e_tc = 0; e_tf = 0; e_ej = 0; e_rt = 0;
    if (!reset_n) begin
      m_state = IDLE; m_tries = 0; m_wait = 0; m_amt = 0; m_accum = 0;
      e_pin_req = 0;
      return;
    end
    case (m_state)
      IDLE: begin
        if (card_insert) begin
          m_state = WAIT_PIN; m_tries = 0; m_wait = 0;
        end
      end
      WAIT_PIN, WAIT_TXN: begin
        event_go = (m_state == WAIT_PIN) ? pin_enter : txn_confirm;
        if (!card_insert) begin
          m_state = IDLE; e_tf = 1;
        end else if (cancel) begin
          m_fail_eject();
        end else if (event_go) begin
          if (m_state == WAIT_PIN) m_state = VERIFY;
          else begin
            m_state = CHECK; m_amt = int'(txn_amount);
          end
        end else if (m_wait == TIMEOUT_CYC - 1) begin
          m_fail_eject();
        end else begin
          m_wait++;
        end
      end
      VERIFY: begin
        if (!card_insert) begin
          m_state = IDLE; e_tf = 1;
        end else if (pin_ack) begin
          if (pin_match) begin
            m_state = WAIT_TXN; m_wait = 0;
          end else begin
            m_tries++;
            if (m_tries == MAX_TRIES) begin
              m_state = RETAIN; e_tf = 1; e_rt = 1;
            end else begin
              m_state = WAIT_PIN; m_wait = 0;
            end
          end
        end
      end
      CHECK: begin
        if (!card_insert) begin
          m_state = IDLE; e_tf = 1;
        end else if (m_amt == 0 || m_amt > bal || (LIMIT_EN && (m_accum + m_amt > DAILY_LIMIT))) begin
          m_fail_eject();
        end else begin
          m_state = DISPENSE; e_ds = 1;
        end
      end
      DISPENSE: begin
        if (disp_fault) begin
          m_fail_eject();
        end else if (disp_done) begin
          m_state = EJECT; e_bwe = 1; e_tc = 1; e_ej = 1;
          e_nb = (bal - m_amt) & ((1 << AMT_W) - 1);
        end
      end
      default: begin
        if (!card_insert) m_state = IDLE;
      end
    endcase
    // Daily total: cleared by day_clr, grows by the amount of a completed
    // withdrawal while its completion pulse is visible.
    if (day_clr) m_accum = 0;
    if (prev_tc) m_accum += m_amt;
    e_pin_req = (m_state == VERIFY);
  endtask

  task automatic compare_all();
    chk_eq("state", state_o, m_state);
    chk_eq("tries", tries, m_tries);
    chk_eq("pin_req", pin_req, e_pin_req);
    chk_eq("disp_start", disp_start, e_ds);
    chk_eq("balance_we", balance_we, e_bwe);
    chk_eq("new_balance", new_balance, e_nb);
    chk_eq("txn_complete", txn_complete, e_tc);
    chk_eq("txn_failed", txn_failed, e_tf);
    chk_eq("card_eject", card_eject, e_ej);
    chk_eq("card_retain", card_retain, e_rt);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic clr_pulses();
    pin_enter = 0; cancel = 0; pin_ack = 0; pin_match = 0;
    txn_confirm = 0; disp_done = 0; disp_fault = 0; day_clr = 0;
  endtask

  // From IDLE with no card: insert, enter PIN, correct PIN -> WAIT_TXN entry.
  task automatic to_wait_txn();
    card_insert = 1; step();
    pin_enter = 1; step(); clr_pulses();
    pin_ack = 1; pin_match = 1; step(); clr_pulses();
  endtask

  task automatic do_reset();
    reset_n = 0; card_insert = 0; clr_pulses();
    step(); step();
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0; card_insert = 0; txn_amount = '0; balance = '0;
    clr_pulses();
    m_state = IDLE; m_tries = 0; m_wait = 0; m_amt = 0; m_accum = 0;
    e_pin_req = 0; e_ds = 0; e_bwe = 0; e_nb = 0; e_tc = 0; e_tf = 0; e_ej = 0; e_rt = 0;

    // Reset state.
    do_reset();
    chk_eq("rst_state", state_o, 0);
    chk_eq("rst_tries", tries, 0);

    // Happy path: balance 200, amount 50.
    to_wait_txn();
    chk_eq("hp_wait_txn", state_o, WAIT_TXN);
    txn_confirm = 1; txn_amount = 16'd50; balance = 16'd200; step(); clr_pulses();
    chk_eq("hp_check", state_o, CHECK);
    step();
    chk_eq("hp_disp_start", disp_start, 1);
    step(); step(); step();
    disp_done = 1; step(); clr_pulses();
    chk_eq("hp_new_balance", new_balance, 150);
    chk_eq("hp_bwe", balance_we, 1);
    chk_eq("hp_tc", txn_complete, 1);
    chk_eq("hp_eject", card_eject, 1);
    step();
    chk_eq("hp_hold_eject", state_o, EJECT);
    card_insert = 0; step();
    chk_eq("hp_idle", state_o, IDLE);

    // Three wrong PINs -> retain.
    card_insert = 1; step();
    for (int i = 0; i < MAX_TRIES; i++) begin
      pin_enter = 1; step(); clr_pulses();
      chk_eq("rt_pin_req", pin_req, 1);
      pin_ack = 1; pin_match = 0; step(); clr_pulses();
      chk_eq("rt_tries", tries, i + 1);
    end
    chk_eq("rt_state", state_o, RETAIN);
    chk_eq("rt_retain", card_retain, 1);
    chk_eq("rt_failed", txn_failed, 1);
    chk_eq("rt_no_eject", card_eject, 0);
    card_insert = 0; step();

    // Idle timeout in WAIT_TXN: EJECT appears 10 cycles after entry.
    to_wait_txn();
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) step();
    chk_eq("to_still_wait", state_o, WAIT_TXN);
    step();
    chk_eq("to_eject_state", state_o, EJECT);
    chk_eq("to_failed", txn_failed, 1);
    chk_eq("to_eject", card_eject, 1);
    card_insert = 0; step();

    // Confirm on the timeout cycle wins; then a dispenser fault.
    to_wait_txn();
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) step();
    txn_confirm = 1; txn_amount = 16'd20; balance = 16'd200; step(); clr_pulses();
    chk_eq("to_confirm_wins", state_o, CHECK);
    step();
    disp_done = 1; disp_fault = 1; step(); clr_pulses();
    chk_eq("flt_failed", txn_failed, 1);
    chk_eq("flt_no_bwe", balance_we, 0);
    chk_eq("flt_no_tc", txn_complete, 0);
    card_insert = 0; step();

    // Amount above balance.
    to_wait_txn();
    txn_confirm = 1; txn_amount = 16'd300; balance = 16'd200; step(); clr_pulses();
    step();
    chk_eq("ovr_state", state_o, EJECT);
    chk_eq("ovr_failed", txn_failed, 1);
    chk_eq("ovr_no_ds", disp_start, 0);
    card_insert = 0; step();

    // Card pulled in VERIFY.
    card_insert = 1; step();
    pin_enter = 1; step(); clr_pulses();
    card_insert = 0; step();
    chk_eq("pull_pin_req", pin_req, 0);
    chk_eq("pull_failed", txn_failed, 1);
    chk_eq("pull_idle", state_o, IDLE);

    // Reset in DISPENSE.
    to_wait_txn();
    txn_confirm = 1; txn_amount = 16'd10; balance = 16'd200; step(); clr_pulses();
    step();
    chk_eq("rd_dispense", state_o, DISPENSE);
    reset_n = 0; step();
    chk_eq("rd_state", state_o, IDLE);
    chk_eq("rd_eject", card_eject, 0);
    reset_n = 1; card_insert = 0; step();

`ifdef ATM_DAILY_LIMIT_EN
    // Daily limit: 400 ok, then 150 refused, day_clr, then 150 ok.
    do_reset();
    balance = 16'd1000;
    to_wait_txn();
    txn_confirm = 1; txn_amount = 16'd400; step(); clr_pulses();
    step();
    disp_done = 1; step(); clr_pulses();
    chk_eq("dl_first_tc", txn_complete, 1);
    card_insert = 0; step();
    to_wait_txn();
    txn_confirm = 1; txn_amount = 16'd150; step(); clr_pulses();
    step();
    chk_eq("dl_second_fail", txn_failed, 1);
    chk_eq("dl_second_no_ds", disp_start, 0);
    card_insert = 0; step();
    day_clr = 1; step(); clr_pulses();
    to_wait_txn();
    txn_confirm = 1; txn_amount = 16'd150; step(); clr_pulses();
    step();
    chk_eq("dl_after_clr_ds", disp_start, 1);
    disp_done = 1; step(); clr_pulses();
    chk_eq("dl_after_clr_nb", new_balance, 850);
    card_insert = 0; step();
`endif

    // Random phase; alternate busy and quiet blocks so timeouts also occur.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int rate;
      rate = (((c / 150) % 2) == 1) ? 4 : 30;
      reset_n     = ($urandom_range(0, 399) != 0);
      card_insert = (m_state >= EJECT) ? ($urandom_range(0, 99) < 60)
                                       : ($urandom_range(0, 99) < 97);
      pin_enter   = ($urandom_range(0, 99) < rate);
      cancel      = ($urandom_range(0, 99) < 4);
      pin_ack     = ($urandom_range(0, 99) < 30);
      pin_match   = ($urandom_range(0, 99) < 65);
      txn_confirm = ($urandom_range(0, 99) < rate);
      txn_amount  = 16'($urandom_range(0, 300));
      balance     = 16'($urandom_range(0, 400));
      disp_done   = ($urandom_range(0, 99) < 25);
      disp_fault  = ($urandom_range(0, 99) < 8);
      day_clr     = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
